// File: rtl/ecc_secded_pipe.sv
// ============================================================================
// Module   : ecc_secded_pipe
// Brief    : Parametrised Hsiao SECDED encoder plus a 2-stage pipelined
//            decoder/corrector with valid/ready handshake, saturating error
//            counters and a first-error syndrome log.
//            Optional macro ECC_ERR_INJECT_EN adds inj_data_mask and
//            inj_parity_mask inputs for fault injection on the read path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_secded_pipe #(
   parameter int DATA_WIDTH   = 32,
   parameter int PARITY_WIDTH = 7,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [DATA_WIDTH-1:0]   enc_data,
   output logic [PARITY_WIDTH-1:0] enc_parity,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic [PARITY_WIDTH-1:0] in_parity,
   input  logic                    bypass,
`ifdef ECC_ERR_INJECT_EN
   input  logic [DATA_WIDTH-1:0]   inj_data_mask,
   input  logic [PARITY_WIDTH-1:0] inj_parity_mask,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic [PARITY_WIDTH-1:0] out_syndrome,
   output logic                    out_sbit_err,
   output logic                    out_dbit_err,
   input  logic                    cnt_clr,
   output logic [CNT_WIDTH-1:0]    sbit_cnt,
   output logic [CNT_WIDTH-1:0]    dbit_cnt,
   output logic                    err_log_valid,
   output logic [PARITY_WIDTH-1:0] err_log_syndrome
);

   localparam int c_nvals = 1 << PARITY_WIDTH;

   function automatic int popcnt(input int v);
      int c;
      c = 0;
      for (int b = 0; b < 32; b++) c += (v >> b) & 1;
      return c;
   endfunction

   // Number of odd-weight (>=3) column candidates available.
   function automatic int count_odd();
      int n;
      n = 0;
      for (int v = 0; v < c_nvals; v++)
         if (popcnt(v) >= 3 && (popcnt(v) % 2) == 1) n++;
      return n;
   endfunction

   // Data columns: odd-weight (>=3) values taken in ascending numeric order.
   function automatic logic [DATA_WIDTH*PARITY_WIDTH-1:0] build_cols();
      logic [DATA_WIDTH*PARITY_WIDTH-1:0] cols;
      int n;
      cols = '0;
      n    = 0;
      for (int v = 0; v < c_nvals; v++) begin
         if (popcnt(v) >= 3 && (popcnt(v) % 2) == 1 && n < DATA_WIDTH) begin
            cols[n*PARITY_WIDTH +: PARITY_WIDTH] = v[PARITY_WIDTH-1:0];
            n++;
         end
      end
      return cols;
   endfunction

   localparam int                                 c_n_odd = count_odd();
   localparam logic [DATA_WIDTH*PARITY_WIDTH-1:0] c_cols  = build_cols();

   if (c_n_odd < DATA_WIDTH || DATA_WIDTH < 2 || DATA_WIDTH > 64) begin : g_bad_cfg
      $error("ecc_secded_pipe: PARITY_WIDTH too small for DATA_WIDTH, or DATA_WIDTH out of 2..64");
   end

   function automatic logic [PARITY_WIDTH-1:0] encode(input logic [DATA_WIDTH-1:0] d);
      logic [PARITY_WIDTH-1:0] p;
      p = '0;
      for (int i = 0; i < DATA_WIDTH; i++)
         if (d[i]) p ^= c_cols[i*PARITY_WIDTH +: PARITY_WIDTH];
      return p;
   endfunction

   // Write-side encoder.
   assign enc_parity = encode(enc_data);

   // Read-side inputs after optional fault injection.
   logic [DATA_WIDTH-1:0]   w_rd_data;
   logic [PARITY_WIDTH-1:0] w_rd_par;
`ifdef ECC_ERR_INJECT_EN
   assign w_rd_data = in_data ^ inj_data_mask;
   assign w_rd_par  = in_parity ^ inj_parity_mask;
`else
   assign w_rd_data = in_data;
   assign w_rd_par  = in_parity;
`endif

   logic                    s1_valid_q, s1_byp_q;
   logic [DATA_WIDTH-1:0]   s1_data_q;
   logic [PARITY_WIDTH-1:0] s1_syn_q;
   logic                    s2_valid_q, s2_sbit_q, s2_dbit_q;
   logic [DATA_WIDTH-1:0]   s2_data_q;
   logic [PARITY_WIDTH-1:0] s2_syn_q;

   logic w_s2_ready, w_out_fire;
   assign w_s2_ready = !s2_valid_q || out_ready;
   assign in_ready   = !s1_valid_q || w_s2_ready;
   assign w_out_fire = s2_valid_q && out_ready;

   // Stage 1: capture the word and its syndrome (forced to 0 when bypassed).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_byp_q   <= 1'b0;
         s1_data_q  <= '0;
         s1_syn_q   <= '0;
      end else if (in_ready) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_byp_q  <= bypass;
            s1_data_q <= w_rd_data;
            s1_syn_q  <= bypass ? '0 : (w_rd_par ^ encode(w_rd_data));
         end
      end
   end

   logic [DATA_WIDTH-1:0] w_fix_data;
   logic                  w_match, w_sbit, w_dbit;

   // Syndrome classification and single-bit correction.
   always_comb begin
      w_fix_data = s1_data_q;
      w_match    = 1'b0;
      w_sbit     = 1'b0;
      w_dbit     = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (s1_syn_q == c_cols[i*PARITY_WIDTH +: PARITY_WIDTH]) begin
            w_fix_data[i] = ~s1_data_q[i];
            w_match       = 1'b1;
         end
      end
      if (!s1_byp_q && s1_syn_q != '0) begin
         if (w_match || $onehot(s1_syn_q)) w_sbit = 1'b1;
         else                              w_dbit = 1'b1;
      end
   end

   // Stage 2: registered corrected word, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_q <= 1'b0;
         s2_sbit_q  <= 1'b0;
         s2_dbit_q  <= 1'b0;
         s2_data_q  <= '0;
         s2_syn_q   <= '0;
      end else if (w_s2_ready) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_sbit_q <= w_sbit;
            s2_dbit_q <= w_dbit;
            s2_data_q <= w_fix_data;
            s2_syn_q  <= s1_syn_q;
         end
      end
   end

   assign out_valid    = s2_valid_q;
   assign out_data     = s2_data_q;
   assign out_syndrome = s2_syn_q;
   assign out_sbit_err = s2_sbit_q;
   assign out_dbit_err = s2_dbit_q;

   logic [CNT_WIDTH-1:0]    sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
   logic                    log_valid_q, log_valid_d;
   logic [PARITY_WIDTH-1:0] log_syn_q, log_syn_d;

   // Counter/log next state; a clear suppresses a same-cycle event.
   always_comb begin
      sbit_cnt_d  = sbit_cnt_q;
      dbit_cnt_d  = dbit_cnt_q;
      log_valid_d = log_valid_q;
      log_syn_d   = log_syn_q;
      if (cnt_clr) begin
         sbit_cnt_d  = '0;
         dbit_cnt_d  = '0;
         log_valid_d = 1'b0;
         log_syn_d   = '0;
      end else if (w_out_fire) begin
         if (s2_sbit_q && sbit_cnt_q != '1) sbit_cnt_d = sbit_cnt_q + CNT_WIDTH'(1);
         if (s2_dbit_q && dbit_cnt_q != '1) dbit_cnt_d = dbit_cnt_q + CNT_WIDTH'(1);
         if ((s2_sbit_q || s2_dbit_q) && !log_valid_q) begin
            log_valid_d = 1'b1;
            log_syn_d   = s2_syn_q;
         end
      end
   end

   // Counter/log state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sbit_cnt_q  <= '0;
         dbit_cnt_q  <= '0;
         log_valid_q <= 1'b0;
         log_syn_q   <= '0;
      end else begin
         sbit_cnt_q  <= sbit_cnt_d;
         dbit_cnt_q  <= dbit_cnt_d;
         log_valid_q <= log_valid_d;
         log_syn_q   <= log_syn_d;
      end
   end

   assign sbit_cnt         = sbit_cnt_q;
   assign dbit_cnt         = dbit_cnt_q;
   assign err_log_valid    = log_valid_q;
   assign err_log_syndrome = log_syn_q;

endmodule

`default_nettype wire

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
- Parametrised SECDED (Hsiao odd-weight-column) encoder plus pipelined decoder/corrector for FIFO and RAM read paths in AS6T28 COMRTL.
- Successor of the fixed-width combinational ECC blocks: generic data width, valid/ready handshake, 2-stage registered decode, saturating error counters and a first-error syndrome log.
- The encoder is combinational on the write side. The decoder sits between the RAM read data and the consumer.

Parameters:
DATA_WIDTH, 32, data bits protected (2..64)
PARITY_WIDTH, 7, check bits; elaboration error if the count of odd-weight (>=3) PARITY_WIDTH-bit values < DATA_WIDTH
CNT_WIDTH, 16, width of the saturating error counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enc_data  in  DATA_WIDTH  write-side data to encode
enc_parity  out  PARITY_WIDTH  combinational check bits of enc_data
in_valid  in  1  read word valid
in_ready  out  1  decoder can accept
in_data  in  DATA_WIDTH  read data
in_parity  in  PARITY_WIDTH  stored check bits
bypass  in  1  sampled with the word; no correction, no error flags
out_valid  out  1  corrected word valid
out_ready  in  1  consumer accepts
out_data  out  DATA_WIDTH  corrected data
out_syndrome  out  PARITY_WIDTH  syndrome of the word (0 when bypass)
out_sbit_err  out  1  single-bit error corrected (data or check bit)
out_dbit_err  out  1  uncorrectable error
cnt_clr  in  1  synchronous clear of counters and log
sbit_cnt  out  CNT_WIDTH  saturating count of single-bit errors
dbit_cnt  out  CNT_WIDTH  saturating count of uncorrectable errors
err_log_valid  out  1  sticky: log holds a captured syndrome
err_log_syndrome  out  PARITY_WIDTH  syndrome of the first error since the last clear

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (rst_n). All registers and outputs reset to 0.
- H-matrix, data columns: column of data bit i = the i-th value, in ascending numeric order, among PARITY_WIDTH-bit values with odd weight >=3. Example: bit0=0x07, bit1=0x0B, bit2=0x0D, bit3=0x0E.
- H-matrix, check columns: check bit j column = 1<<j.
- Encode: enc_parity[j] = XOR of enc_data[i] over all i whose column has bit j set. The same function is applied internally to in_data.
- Stage 1 (on in_valid && in_ready): register data, bypass, and syndrome = in_parity ^ encode(in_data).
- Stage 2:
  - Syndrome 0 -> no error.
  - Syndrome equals a data column -> flip that bit, sbit=1.
  - Syndrome is one-hot -> check-bit error, data unchanged, sbit=1.
  - Any other odd weight, or any even nonzero weight -> data unchanged, dbit=1.
  - bypass=1 -> data passes unchanged, flags=0, out_syndrome=0.
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Throughput is 1 word/clk.
- Handshake:
  - s2_ready = !s2_valid || out_ready.
  - in_ready = !s1_valid || s2_ready.
  - Stage contents hold while stalled. No bubbles are inserted and no words are dropped or duplicated.
  - out_* are stable while out_valid && !out_ready.
- Counters:
  - Increment on the output handshake when the respective flag is set.
  - Saturate at all-ones.
  - cnt_clr wins over a same-cycle increment; that event is not counted.
- Error log:
  - On the first flagged handshake while err_log_valid=0, capture out_syndrome and set err_log_valid.
  - Later errors do not overwrite the log.
  - cnt_clr clears the log. If cnt_clr and an error handshake occur in the same cycle, the log stays empty.
- Reset mid-operation: in-flight words are discarded; out_valid=0 the cycle after assertion.

Optional Feature:
- Macro: ECC_ERR_INJECT_EN.
- Defined: adds ports inj_data_mask (DATA_WIDTH) and inj_parity_mask (PARITY_WIDTH). These are XORed into in_data/in_parity before the stage-1 syndrome for the word accepted that cycle. Used for BIST and lab fault tests.
- Undefined: ports absent; behaviour identical to zero masks.

Test Plan:
- Clean word: encode enc_data=0x00000001 -> enc_parity=0x07. Send in_data=0x00000001, in_parity=0x07 -> out_data=0x00000001 two cycles later, flags 0, syndrome 0x00.
- Single data error: in_data=0x00000000, in_parity=0x07 -> out_syndrome=0x07, out_data=0x00000001, sbit=1, sbit_cnt=1, err_log_syndrome=0x07.
- Check-bit error and double error:
  - in_data=0, in_parity=0x01 -> sbit=1, out_data=0.
  - in_data=0x00000003, in_parity=0 -> syndrome 0x0C, dbit=1, out_data=0x00000003 unchanged, dbit_cnt=1.
- Backpressure: stream 8 words with out_ready toggling 1010... -> all 8 words emerge in order, no loss or duplication, out_* stable during stalls, in_ready=0 only when both stages are full and stalled.
- Saturation/clear: CNT_WIDTH=2, send 5 single-bit errors -> sbit_cnt=3. Pulse cnt_clr together with a 6th error -> sbit_cnt=0, err_log_valid=0.
- Bypass and reset: bypass=1 with in_parity=0x01 -> flags 0, counters unchanged. Assert rst_n low while both stages are full -> out_valid=0, all counters 0.
